tx_frame_ctrl: RTL and testbench
================================

Name: tx_frame_ctrl

Overview:
- Controller that sequences the 16-byte transmit buffer path.
- Accepts bytes from a producer into a 16 x 8 store; `tbnfout` is high while there is room.
- On a flush request (`tfin`) or when the store fills, emits the stored bytes oldest-first to a downstream link with a valid/ready handshake, marking the last byte of the frame.
- When the frame is fully sent, empties the store and returns to accepting bytes.

Parameters:
- WIDTH, 8, data byte width.
- DEPTH, 16, bytes per frame (store size); must be a power of 2.
- CW, 5, count width; holds 0..DEPTH inclusive.

Ports:
- clk  input  1  system clock; all state updates on its rising edge
- reset  input  1  asynchronous, active-high reset
- datain  input  WIDTH  byte from producer
- wen  input  1  producer write strobe; byte accepted when wen && tbnfout
- tfin  input  1  flush request; starts transmission of a partial frame
- tbnfout  output  1  buffer not full and accepting (1 only in FILL with count<DEPTH)
- dataout  output  WIDTH  byte presented to downstream; 0 when txvalid=0
- txvalid  output  1  dataout valid
- txready  input  1  downstream accepts dataout this cycle
- txlast  output  1  dataout is final byte of frame (qualified by txvalid)
- countout  output  CW  bytes currently held in frame
- busy  output  1  1 in SEND

Behaviour:
- Reset (async, immediate):
  - state=FILL, count=0, rdptr=0.
  - Outputs: tbnfout=1, txvalid=0, txlast=0, dataout=0, countout=0, busy=0.
  - Store contents are don't-care.
  - Reset mid-SEND aborts the frame; no further txvalid until a new frame.
- States: FILL, SEND. All outputs are decoded from registered state, count and rdptr; there is no combinational path from txready to txvalid.
- FILL:
  - Write accepted when wen && count<DEPTH: store[count]<=datain, count<=count+1.
  - Go to SEND if an accepted write makes count==DEPTH (auto-send, no tfin needed).
  - Go to SEND if tfin && (count>0 || write accepted this cycle). A same-cycle write is included in the frame.
  - tfin with count==0 and no write: ignored, stay in FILL.
- SEND:
  - txvalid=1, dataout=store[rdptr], txlast=(rdptr==count-1), busy=1, tbnfout=0.
  - wen and tfin are ignored; writes are dropped and do not change count.
  - Transfer occurs on txvalid && txready: rdptr<=rdptr+1.
  - If the transfer carries txlast: count<=0, rdptr<=0, state<=FILL. tbnfout returns to 1 the following cycle.
  - txready low: dataout, txlast and rdptr hold stable indefinitely.
- Latency:
  - First byte is valid the cycle after the transition edge.
  - One byte per cycle with txready held high, so an N-byte frame takes N cycles in SEND.
- Arithmetic: count and rdptr are unsigned CW bits and never wrap; count is saturated by the tbnfout gating. countout=count at all times, including during SEND.
- Order: bytes are emitted in the order written (FIFO), never reordered.

Test Plan:
1. Reset: assert reset asynchronously between clock edges -> all outputs reset immediately: tbnfout=1, txvalid=0, txlast=0, dataout=0x00, countout=0, busy=0.
2. Partial flush: write 0x11, 0x22, 0x33, then pulse tfin, with txready=1 ->
   - next cycle txvalid=1 and dataout=0x11;
   - then 0x22, then 0x33 with txlast=1;
   - following cycle txvalid=0, countout=0, tbnfout=1.
3. Auto-send on full: write 0x00..0x0F on consecutive cycles ->
   - after the 16th write, countout=16 and tbnfout=0;
   - SEND is entered without tfin;
   - a 17th write of 0xFF is dropped;
   - 16 bytes 0x00..0x0F come out, with txlast on 0x0F.
4. Backpressure: 4-byte frame 0xA0..0xA3; hold txready=0 for 4 cycles after the first byte is valid ->
   - dataout stays 0xA0 and txvalid stays 1;
   - on release, the sequence continues 0xA1..0xA3 with no loss or duplication.
5. Flush boundary cases:
   - tfin with count=0 -> no state change, txvalid stays 0.
   - tfin in the same cycle as a write of 0xAA into an empty store -> 1-byte frame, dataout=0xAA with txvalid=1 and txlast=1 together.
6. Reset mid-frame: 5-byte frame, assert reset after 2 bytes transfer ->
   - txvalid=0 and countout=0 immediately;
   - after release, write 0x55 and pulse tfin -> a clean 1-byte frame 0x55 with txlast=1.

Source files
------------

// File: rtl/tx_frame_ctrl.sv
// ---------------------------------------------------------------------------
// tx_frame_ctrl
//
// Transmit frame controller. Bytes from a producer are collected into a
// DEPTH-entry store. When the producer requests a flush (tfin) or the store
// fills, the collected bytes are emitted oldest-first to a downstream link
// over a valid/ready handshake, with the final byte of the frame flagged.
// Once the last byte has been accepted, the store is emptied and the block
// goes back to accepting bytes.
//
// Ports:
//   clk      in   system clock, all state changes on its rising edge
//   reset    in   asynchronous active-high reset
//   datain   in   [WIDTH] byte from producer
//   wen      in   producer write strobe (accepted when wen && tbnfout)
//   tfin     in   flush request, sends a partial frame
//   tbnfout  out  store has room and is accepting bytes
//   dataout  out  [WIDTH] byte to downstream, 0 when txvalid is low
//   txvalid  out  dataout is valid
//   txready  in   downstream accepts dataout this cycle
//   txlast   out  dataout is the final byte of the frame
//   countout out  [CW] number of bytes held in the current frame
//   busy     out  frame transmission in progress
// ---------------------------------------------------------------------------
module tx_frame_ctrl #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int CW    = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] datain,
    input  logic             wen,
    input  logic             tfin,
    output logic             tbnfout,
    output logic [WIDTH-1:0] dataout,
    output logic             txvalid,
    input  logic             txready,
    output logic             txlast,
    output logic [CW-1:0]    countout,
    output logic             busy
);

    // Address width of the store; the count is one bit wider so it can
    // represent a completely full store.
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {
        FILL = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t          state_reg;
    logic [CW-1:0]   count_reg;
    logic [CW-1:0]   rdptr_reg;
    logic [WIDTH-1:0] store [DEPTH];

    logic wr_accept;
    logic is_last;
    logic in_send;

    assign in_send   = (state_reg == SEND);

    // The count only advances on accepted writes, so gating on count<DEPTH
    // is what keeps it from ever exceeding DEPTH.
    assign wr_accept = (state_reg == FILL) && wen && (count_reg < CW'(DEPTH));

    // In SEND the count is always at least 1, so count-1 never underflows
    // while the comparison is actually used.
    assign is_last   = (rdptr_reg == (count_reg - CW'(1)));

    // Storage has no reset: its contents are meaningless until written, and
    // leaving it reset-free keeps it mappable onto distributed RAM. The read
    // side is asynchronous so the first byte is presented in the very first
    // SEND cycle and holds for as long as the downstream stalls.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            store[count_reg[AW-1:0]] <= datain;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= FILL;
            count_reg <= '0;
            rdptr_reg <= '0;
        end else begin
            case (state_reg)
                FILL: begin
                    if (wr_accept) begin
                        count_reg <= count_reg + CW'(1);
                        // A same-cycle flush includes the byte being written.
                        if ((count_reg == CW'(DEPTH - 1)) || tfin) begin
                            state_reg <= SEND;
                        end
                    end else if (tfin && (count_reg != '0)) begin
                        state_reg <= SEND;
                    end
                end
                SEND: begin
                    // Producer strobes are ignored here; only the downstream
                    // handshake moves the read pointer.
                    if (txready) begin
                        if (is_last) begin
                            count_reg <= '0;
                            rdptr_reg <= '0;
                            state_reg <= FILL;
                        end else begin
                            rdptr_reg <= rdptr_reg + CW'(1);
                        end
                    end
                end
                default: begin
                    state_reg <= FILL;
                end
            endcase
        end
    end

    // All outputs decode from registered state only; txready never reaches
    // txvalid combinationally.
    assign busy     = in_send;
    assign txvalid  = in_send;
    assign txlast   = in_send && is_last;
    assign dataout  = in_send ? store[rdptr_reg[AW-1:0]] : '0;
    assign tbnfout  = (state_reg == FILL) && (count_reg < CW'(DEPTH));
    assign countout = count_reg;

endmodule

// File: tb/tb_tx_frame_ctrl.sv
// ---------------------------------------------------------------------------
// tb_tx_frame_ctrl
//
// Self-checking bench for tx_frame_ctrl. Expected bytes (with their last
// flag) are pushed into a scoreboard queue as they are written and popped
// when the DUT hands them over on the valid/ready interface.
// ---------------------------------------------------------------------------
module tb_tx_frame_ctrl;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int CW    = 5;

    logic             clk;
    logic             reset;
    logic [WIDTH-1:0] datain;
    logic             wen;
    logic             tfin;
    logic             tbnfout;
    logic [WIDTH-1:0] dataout;
    logic             txvalid;
    logic             txready;
    logic             txlast;
    logic [CW-1:0]    countout;
    logic             busy;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             last;
    } exp_t;

    exp_t sb[$];
    int   frame_len;
    int   n_cmp;
    int   n_err;
    int   n_xfer;

    tx_frame_ctrl #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .CW   (CW)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .datain  (datain),
        .wen     (wen),
        .tfin    (tfin),
        .tbnfout (tbnfout),
        .dataout (dataout),
        .txvalid (txvalid),
        .txready (txready),
        .txlast  (txlast),
        .countout(countout),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One write cycle. The expected byte is queued; it is marked last when
    // this write flushes or fills the store.
    task automatic write_byte(input logic [WIDTH-1:0] d, input logic flush);
        exp_t e;
        wen    = 1'b1;
        datain = d;
        tfin   = flush;
        frame_len++;
        e.data = d;
        e.last = flush || (frame_len == DEPTH);
        sb.push_back(e);
        if (e.last) frame_len = 0;
        @(negedge clk);
        wen  = 1'b0;
        tfin = 1'b0;
    endtask

    task automatic pulse_tfin();
        tfin = 1'b1;
        if (frame_len > 0) begin
            sb[sb.size()-1].last = 1'b1;
            frame_len = 0;
        end
        @(negedge clk);
        tfin = 1'b0;
    endtask

    // Receive bytes from the DUT. Called at a negedge right after the cycle
    // that should have entered SEND. txready is held low for the first
    // stall_len cycles; stops after max_xfers transfers (0 = whole frame).
    task automatic drain(input int stall_len, input int max_xfers, input string tag);
        int   cyc;
        int   xfers;
        bit   finish;
        bit   saw_last;
        exp_t e;
        cyc      = 0;
        xfers    = 0;
        finish   = 1'b0;
        saw_last = 1'b0;
        n_cmp++;
        if (txvalid !== 1'b1) begin
            n_err++;
            $display("FAIL %s first_valid: txvalid=%b required 1", tag, txvalid);
        end
        while (!finish) begin
            txready = 1'b1;
            if (txvalid === 1'b1) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL %s unexpected_byte: dataout=%02h required none", tag, dataout);
                    finish = 1'b1;
                end else begin
                    e = sb[0];
                    n_cmp++;
                    if (dataout !== e.data) begin
                        n_err++;
                        $display("FAIL %s dataout: got %02h required %02h", tag, dataout, e.data);
                    end
                    n_cmp++;
                    if (txlast !== e.last) begin
                        n_err++;
                        $display("FAIL %s txlast: got %b required %b (data %02h)", tag, txlast, e.last, e.data);
                    end
                    if (cyc < stall_len) begin
                        txready = 1'b0;
                    end else begin
                        void'(sb.pop_front());
                        xfers++;
                        n_xfer++;
                        $display("xfer %0d [%s]: data=%02h last=%0b", n_xfer, tag, e.data, e.last);
                        if (e.last) saw_last = 1'b1;
                        if (e.last || (xfers == max_xfers)) finish = 1'b1;
                    end
                end
            end
            @(negedge clk);
            cyc++;
            if (!finish && cyc > 200) begin
                n_cmp++;
                n_err++;
                $display("FAIL %s timeout: %0d bytes received, frame not completed", tag, xfers);
                finish = 1'b1;
            end
        end
        if (saw_last) begin
            n_cmp++;
            if (txvalid !== 1'b0 || countout !== '0 || tbnfout !== 1'b1 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL %s after_frame: txvalid=%b countout=%0d tbnfout=%b busy=%b required 0/0/1/0",
                         tag, txvalid, countout, tbnfout, busy);
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        n_cmp++;
        if (tbnfout !== 1'b1 || txvalid !== 1'b0 || txlast !== 1'b0 ||
            dataout !== 8'h00 || countout !== '0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL %s: tbnfout=%b txvalid=%b txlast=%b dataout=%02h countout=%0d busy=%b required 1/0/0/00/0/0",
                     tag, tbnfout, txvalid, txlast, dataout, countout, busy);
        end
    endtask

    task automatic test_reset();
        #3;
        check_reset_outputs("reset_initial");
        @(negedge clk);
        reset = 1'b0;
        write_byte(8'h5A, 1'b0);
        n_cmp++;
        if (countout !== CW'(1)) begin
            n_err++;
            $display("FAIL reset_prewrite countout: got %0d required 1", countout);
        end
        // Assert between edges and look before the next rising edge.
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs("reset_async");
        sb.delete();
        frame_len = 0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset_release");
    endtask

    task automatic test_partial_flush();
        write_byte(8'h11, 1'b0);
        write_byte(8'h22, 1'b0);
        write_byte(8'h33, 1'b0);
        n_cmp++;
        if (countout !== CW'(3) || txvalid !== 1'b0) begin
            n_err++;
            $display("FAIL partial_prefill: countout=%0d txvalid=%b required 3/0", countout, txvalid);
        end
        pulse_tfin();
        drain(0, 0, "partial");
    endtask

    task automatic test_auto_send();
        txready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            write_byte(WIDTH'(i), 1'b0);
        end
        n_cmp++;
        if (countout !== CW'(16) || tbnfout !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL auto_full: countout=%0d tbnfout=%b busy=%b required 16/0/1", countout, tbnfout, busy);
        end
        // A write while sending must be dropped.
        wen    = 1'b1;
        datain = 8'hFF;
        tfin   = 1'b1;
        @(negedge clk);
        wen  = 1'b0;
        tfin = 1'b0;
        n_cmp++;
        if (countout !== CW'(16) || dataout !== 8'h00) begin
            n_err++;
            $display("FAIL auto_drop: countout=%0d dataout=%02h required 16/00", countout, dataout);
        end
        drain(0, 0, "auto");
    endtask

    task automatic test_backpressure();
        txready = 1'b0;
        write_byte(8'hA0, 1'b0);
        write_byte(8'hA1, 1'b0);
        write_byte(8'hA2, 1'b0);
        write_byte(8'hA3, 1'b0);
        pulse_tfin();
        drain(4, 0, "backpressure");
    endtask

    task automatic test_flush_boundary();
        pulse_tfin();
        n_cmp++;
        if (txvalid !== 1'b0 || busy !== 1'b0 || countout !== '0 || tbnfout !== 1'b1) begin
            n_err++;
            $display("FAIL empty_flush: txvalid=%b busy=%b countout=%0d tbnfout=%b required 0/0/0/1",
                     txvalid, busy, countout, tbnfout);
        end
        write_byte(8'hAA, 1'b1);
        drain(0, 0, "single_byte");
    endtask

    task automatic test_reset_mid_frame();
        write_byte(8'hC0, 1'b0);
        write_byte(8'hC1, 1'b0);
        write_byte(8'hC2, 1'b0);
        write_byte(8'hC3, 1'b0);
        write_byte(8'hC4, 1'b1);
        drain(0, 2, "midframe");
        #2;
        reset = 1'b1;
        #1;
        n_cmp++;
        if (txvalid !== 1'b0 || countout !== '0 || busy !== 1'b0 || dataout !== 8'h00) begin
            n_err++;
            $display("FAIL midframe_reset: txvalid=%b countout=%0d busy=%b dataout=%02h required 0/0/0/00",
                     txvalid, countout, busy, dataout);
        end
        sb.delete();
        frame_len = 0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (txvalid !== 1'b0) begin
            n_err++;
            $display("FAIL midframe_quiet: txvalid=%b required 0", txvalid);
        end
        write_byte(8'h55, 1'b0);
        pulse_tfin();
        drain(0, 0, "post_reset");
    endtask

    task automatic test_back_to_back();
        write_byte(8'h01, 1'b0);
        write_byte(8'h02, 1'b1);
        drain(0, 0, "b2b_a");
        write_byte(8'h03, 1'b1);
        drain(0, 0, "b2b_b");
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        n_xfer    = 0;
        frame_len = 0;
        reset     = 1'b1;
        datain    = '0;
        wen       = 1'b0;
        tfin      = 1'b0;
        txready   = 1'b1;

        test_reset();
        test_partial_flush();
        test_auto_send();
        test_backpressure();
        test_flush_boundary();
        test_reset_mid_frame();
        test_back_to_back();

        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_empty: %0d bytes never delivered, required 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
